axis_uart_rx: RTL

//  UART receiver: deserialises the rx line into bytes and presents them on an AXI-Stream master.

---
 rtl/axis_uart_pkg.sv | 53 +++++
 rtl/axis_uart_sync.sv | 37 +++
 rtl/axis_uart_rx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_uart_pkg.sv
// rtl/axis_uart_pkg.sv - shared UART types, constants and parity helper
//
// Purpose: common definitions for the UART transmit and receive paths.
//   DATA_WIDTH             bits per character
//   MIN_CLK_DIVIDER        smallest usable bit period in clk cycles
//   uart_state_e           frame state machine states
//   uart_parity_reg_t      parity register: bit0 odd enable, bit1 even enable
//   uart_clk_divider_reg_t clk cycles per bit
//   uart_rx_user_t         per-byte receive status {frame_err, parity_err}
//   parity()               parity bit a correct frame carries for the given mode
package axis_uart_pkg;

   localparam int          DATA_WIDTH      = 8;
   localparam logic [31:0] MIN_CLK_DIVIDER = 32'd4;

   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_PARITY,
      UART_STOP,
      UART_WAIT
   } uart_state_e;

   typedef struct packed {
      logic even;
      logic odd;
   } uart_parity_mode_t;

   typedef struct packed {
      logic [29:0]       reserved;
      uart_parity_mode_t mode;
   } uart_parity_reg_t;

   typedef logic [31:0] uart_clk_divider_reg_t;

   typedef struct packed {
      logic frame_err;
      logic parity_err;
   } uart_rx_user_t;

   // Odd wins when both enables are set; with neither set the result is unused.
   function automatic logic parity(input logic [DATA_WIDTH-1:0] data,
                                   input uart_parity_mode_t     mode);
      if (mode.odd) begin
         return ~(^data);
      end else if (mode.even) begin
         return ^data;
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/axis_uart_sync.sv
// rtl/axis_uart_sync.sv - flop-chain synchroniser for one asynchronous input
//
// Purpose: brings an asynchronous level into the clk_i domain. The chain resets
// to 1 so an idle-high serial line does not look like a start bit after reset.
// STAGES must be at least 2.
// Ports:
//   clk_i    in  1  destination clock
//   arstn_i  in  1  asynchronous active-low reset
//   d_i      in  1  asynchronous input
//   q_o      out 1  synchronised output, STAGES cycles behind d_i
module axis_uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic arstn_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/axis_uart_rx.sv
// rtl/axis_uart_rx.sv - UART receiver presenting bytes on an AXI-Stream master
//
// Purpose: deserialises the rx line (start, 8 data bits LSB first, optional
// parity, stop) and delivers each byte with its error flags on m_axis.
// Bit period and parity mode are latched when a start bit is detected.
// Optional feature macro: AXIS_UART_RX_MAJORITY_EN -- each bit is the 2-of-3
// vote of the samples at mid-1, mid and mid+1 (decision one cycle later).
// Ports:
//   clk_i          in  1   system clock
//   arstn_i        in  1   asynchronous active-low reset
//   uart_rx_i      in  1   serial line, idle high, asynchronous
//   clk_divider_i  in  32  clk cycles per bit (clamped to >= 4)
//   parity_i       in  32  bit0 odd, bit1 even; both 0 = no parity bit
//   m_axis_tdata   out 8   received byte
//   m_axis_tuser   out 2   {frame_err, parity_err}
//   m_axis_tvalid  out 1   byte available
//   m_axis_tready  in  1   sink accepts
//   overrun_o      out 1   one-cycle pulse: byte dropped because output was full
module axis_uart_rx
   import axis_uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        uart_rx_i,
   input  logic [31:0] clk_divider_i,
   input  logic [31:0] parity_i,
   output logic [7:0]  m_axis_tdata,
   output logic [1:0]  m_axis_tuser,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        overrun_o
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

   logic                  rx_sync;
   logic                  sample_bit;
   logic [31:0]           start_tgt;
   logic                  bit_end;
   logic [31:0]           n_start;
   uart_clk_divider_reg_t div_reg;
   uart_parity_reg_t      parity_reg;
   logic                  unused_parity_bits;

   uart_state_e           state_q,   state_d;
   logic [31:0]           cnt_q,     cnt_d;
   logic [2:0]            bit_q,     bit_d;
   logic [7:0]            shreg_q,   shreg_d;
   logic [31:0]           n_q,       n_d;
   uart_parity_mode_t     mode_q,    mode_d;
   logic                  perr_q,    perr_d;
   logic [7:0]            tdata_q,   tdata_d;
   uart_rx_user_t         tuser_q,   tuser_d;
   logic                  tvalid_q,  tvalid_d;
   logic                  overrun_q, overrun_d;

   axis_uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_rx_sync (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .d_i     (uart_rx_i),
      .q_o     (rx_sync)
   );

   assign div_reg            = clk_divider_i;
   assign parity_reg         = parity_i;
   assign unused_parity_bits = ^parity_reg.reserved;
   assign n_start            = (div_reg < MIN_CLK_DIVIDER) ? MIN_CLK_DIVIDER : div_reg;

   // Every bit after the start bit ends when the counter has run N cycles.
   assign bit_end = (cnt_q == n_q - 32'd1);

`ifdef AXIS_UART_RX_MAJORITY_EN
   // hist_q[0] holds the mid sample, hist_q[1] mid-1, rx_sync is mid+1 at the
   // decision cycle, which is why the start decision moves one cycle later.
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d = {hist_q[0], rx_sync};
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign sample_bit = (rx_sync & hist_q[0]) | (rx_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
   assign start_tgt  = n_q >> 1;
`else
   assign sample_bit = rx_sync;
   // START is entered one cycle after the synced edge, so the mid-bit
   // decision falls when the counter shows half-1.
   assign start_tgt  = (n_q >> 1) - 32'd1;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 32'd1;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      n_d       = n_q;
      mode_d    = mode_q;
      perr_d    = perr_q;
      tdata_d   = tdata_q;
      tuser_d   = tuser_q;
      tvalid_d  = tvalid_q;
      overrun_d = 1'b0;

      if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
      end

      case (state_q)
         UART_IDLE: begin
            cnt_d = '0;
            if (!rx_sync) begin
               state_d = UART_START;
               n_d     = n_start;
               mode_d  = parity_reg.mode;
               perr_d  = 1'b0;
            end
         end

         UART_START: begin
            if (cnt_q == start_tgt) begin
               cnt_d = '0;
               bit_d = '0;
               // A high sample here means the falling edge was a glitch.
               state_d = sample_bit ? UART_IDLE : UART_DATA;
            end
         end

         UART_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shreg_d = {sample_bit, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == LAST_BIT) begin
                  state_d = (mode_q.odd || mode_q.even) ? UART_PARITY : UART_STOP;
               end
            end
         end

         UART_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               perr_d  = (sample_bit != parity(shreg_q, mode_q));
               state_d = UART_STOP;
            end
         end

         UART_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Re-arm at mid-stop; a low stop bit means break or framing
               // error, so wait for the line to return high first.
               state_d = sample_bit ? UART_IDLE : UART_WAIT;
               if (!tvalid_q || m_axis_tready) begin
                  tdata_d            = shreg_q;
                  tuser_d.frame_err  = ~sample_bit;
                  tuser_d.parity_err = perr_q;
                  tvalid_d           = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end

         UART_WAIT: begin
            cnt_d = '0;
            if (rx_sync) begin
               state_d = UART_IDLE;
            end
         end

         default: begin
            state_d = UART_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q   <= UART_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         n_q       <= '0;
         mode_q    <= '0;
         perr_q    <= 1'b0;
         tdata_q   <= '0;
         tuser_q   <= '0;
         tvalid_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         n_q       <= n_d;
         mode_q    <= mode_d;
         perr_q    <= perr_d;
         tdata_q   <= tdata_d;
         tuser_q   <= tuser_d;
         tvalid_q  <= tvalid_d;
         overrun_q <= overrun_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tvalid = tvalid_q;
   assign overrun_o     = overrun_q;

endmodule
